// File: rtl/round_sched_if.sv
// Signal bundle between the round scheduler and the rest of the reaction game.
// Event protocol: slowen is a one-clk strobe, rand_bit is fresh every clk, btn is a synchronized level.
interface round_sched_if;
    logic       slowen;
    logic       rand_bit;
    logic       btn;
    logic       leds_on;
    logic [1:0] led_control;
    logic       clear;
    logic       winrnd;
    logic [3:0] score;
    logic       game_over;
    logic       win;

    modport slave (
        input  slowen, rand_bit, btn,
        output leds_on, led_control, clear, winrnd, score, game_over, win
    );

    modport master (
        output slowen, rand_bit, btn,
        input  leds_on, led_control, clear, winrnd, score, game_over, win
    );
endinterface

// File: rtl/round_sched.sv
// Round sequencer for the LED reaction game: random pre-delay, lit window, press judging, scoring.
// Every output is a register updated on the transition into the state that owns it.
module round_sched #(
    parameter int ROUNDS     = 8,
    parameter int MIN_DELAY  = 4,
    parameter int WINDOW     = 16,
    parameter int WIN_THRESH = 6
) (
    input  logic         clk,
    input  logic         rst,
    round_sched_if.slave bus,
    output logic [2:0]   fsm_state
);
    localparam int DW = $clog2(MIN_DELAY + 16);
    localparam int WW = $clog2(WINDOW + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_WAIT = 3'd2,
        S_SHOW = 3'd3,
        S_HIT  = 3'd4,
        S_MISS = 3'd5,
        S_NEXT = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t          state;
    logic [3:0]      rand_sr;
    logic            btn_q;
    logic            press;
    logic [3:0]      round;
    logic [DW-1:0]   dly;
    logic [DW-1:0]   dly_load;
    logic [WW-1:0]   win_cnt;

    logic            leds_on_r;
    logic [1:0]      led_control_r;
    logic            clear_r;
    logic            winrnd_r;
    logic [3:0]      score_r;
    logic            game_over_r;
    logic            win_r;

    assign press    = bus.btn & ~btn_q;
    assign dly_load = DW'(MIN_DELAY) + DW'(rand_sr);

    assign fsm_state       = state;
    assign bus.leds_on     = leds_on_r;
    assign bus.led_control = led_control_r;
    assign bus.clear       = clear_r;
    assign bus.winrnd      = winrnd_r;
    assign bus.score       = score_r;
    assign bus.game_over   = game_over_r;
    assign bus.win         = win_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            rand_sr       <= 4'd0;
            btn_q         <= 1'b1;   // a button held through reset must not count as a press
            round         <= 4'd0;
            dly           <= '0;
            win_cnt       <= '0;
            leds_on_r     <= 1'b0;
            led_control_r <= 2'd0;
            clear_r       <= 1'b0;
            winrnd_r      <= 1'b0;
            score_r       <= 4'd0;
            game_over_r   <= 1'b0;
            win_r         <= 1'b0;
        end else begin
            rand_sr  <= {rand_sr[2:0], bus.rand_bit};
            btn_q    <= bus.btn;
            clear_r  <= 1'b0;
            winrnd_r <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (press) begin
                        state         <= S_CLR;
                        clear_r       <= 1'b1;
                        score_r       <= 4'd0;
                        round         <= 4'd0;
                        led_control_r <= 2'd0;
                    end
                end
                S_CLR: begin
                    state <= S_WAIT;
                    dly   <= dly_load;
                end
                S_WAIT: begin
                    // An early press beats a terminal tick: the LED was never lit.
                    if (press) begin
                        state <= S_MISS;
                    end else if (bus.slowen) begin
                        if (dly == DW'(1)) begin
                            state         <= S_SHOW;
                            leds_on_r     <= 1'b1;
                            led_control_r <= rand_sr[1:0];
                            win_cnt       <= WW'(WINDOW);
                        end else begin
                            dly <= dly - DW'(1);
                        end
                    end
                end
                S_SHOW: begin
                    if (press) begin
                        state     <= S_HIT;
                        leds_on_r <= 1'b0;
                        winrnd_r  <= 1'b1;
                        score_r   <= (score_r == 4'd15) ? score_r : score_r + 4'd1;
                    end else if (bus.slowen) begin
                        if (win_cnt == WW'(1)) begin
                            state     <= S_MISS;
                            leds_on_r <= 1'b0;
                        end else begin
                            win_cnt <= win_cnt - WW'(1);
                        end
                    end
                end
                S_HIT, S_MISS: begin
                    state <= S_NEXT;
                    round <= round + 4'd1;
                end
                S_NEXT: begin
                    if (round == 4'(ROUNDS)) begin
                        state       <= S_DONE;
                        game_over_r <= 1'b1;
                        win_r       <= (32'(score_r) >= WIN_THRESH);
                    end else begin
                        state <= S_WAIT;
                        dly   <= dly_load;
                    end
                end
                S_DONE: begin
                    if (press) begin
                        state         <= S_CLR;
                        clear_r       <= 1'b1;
                        score_r       <= 4'd0;
                        round         <= 4'd0;
                        led_control_r <= 2'd0;
                        game_over_r   <= 1'b0;
                        win_r         <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_round_sched.sv
// Bench for round_sched: scripted and random games against a sequential behavioural model of a game.
// The model walks a game round by round and publishes the outputs each cycle should show.
module tb_round_sched;
    localparam int ROUNDS     = 8;
    localparam int MIN_DELAY  = 4;
    localparam int WINDOW     = 16;
    localparam int WIN_THRESH = 6;

    logic       clk;
    logic       rst;
    logic [2:0] fsm_state;

    round_sched_if bus ();

    round_sched #(
        .ROUNDS(ROUNDS), .MIN_DELAY(MIN_DELAY), .WINDOW(WINDOW), .WIN_THRESH(WIN_THRESH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .fsm_state(fsm_state)
    );

    int checks   = 0;
    int failures = 0;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // behavioural model state and expected outputs
    bit         m_live     = 1'b0;
    int         m_phase    = 0;   // 0 idle, 1 clear, 2 wait, 3 show, 4 result, 5 next, 6 done
    int         m_ticks    = 0;
    int         m_need     = 0;
    logic [3:0] m_hist     = 4'd0;
    logic [3:0] cur_hist   = 4'd0;
    bit         m_btn_prev = 1'b1;
    logic       e_leds, e_clear, e_winrnd, e_over, e_win;
    logic [1:0] e_led;
    logic [3:0] e_score;

    task automatic m_edge(output bit p, output bit s, output bit ab);
        @(posedge clk);
        e_clear  = 1'b0;
        e_winrnd = 1'b0;
        if (rst) begin
            ab = 1'b1; p = 1'b0; s = 1'b0;
            e_leds = 1'b0; e_led = 2'd0; e_score = 4'd0; e_over = 1'b0; e_win = 1'b0;
            m_hist = 4'd0; m_btn_prev = 1'b1; m_phase = 0; m_ticks = 0; m_live = 1'b1;
            return;
        end
        ab = 1'b0;
        p = bus.btn & ~m_btn_prev;
        s = bus.slowen;
        cur_hist = m_hist;
        m_hist = {m_hist[2:0], bus.rand_bit};
        m_btn_prev = bus.btn;
    endtask

    task automatic run_model();
        bit p, s, ab, hit, early;
        int d, t;
        m_phase = 0;
        do begin m_edge(p, s, ab); if (ab) return; end while (!p);
        forever begin
            m_phase = 1; e_clear = 1'b1; e_score = 4'd0; e_led = 2'd0;
            e_over = 1'b0; e_win = 1'b0; e_leds = 1'b0;
            m_edge(p, s, ab); if (ab) return;
            for (int r = 0; r < ROUNDS; r++) begin
                d = MIN_DELAY + int'(cur_hist);
                m_need = d; m_ticks = 0; m_phase = 2;
                early = 1'b0; hit = 1'b0; t = 0;
                forever begin
                    m_edge(p, s, ab); if (ab) return;
                    if (p) begin early = 1'b1; break; end
                    if (s) begin t++; m_ticks = t; if (t == d) break; end
                end
                if (!early) begin
                    m_phase = 3; e_leds = 1'b1; e_led = cur_hist[1:0]; t = 0; m_ticks = 0;
                    forever begin
                        m_edge(p, s, ab); if (ab) return;
                        if (p) begin hit = 1'b1; break; end
                        if (s) begin t++; m_ticks = t; if (t == WINDOW) break; end
                    end
                    e_leds = 1'b0;
                end
                m_phase = 4;
                if (hit) begin
                    e_winrnd = 1'b1;
                    if (e_score != 4'd15) e_score = e_score + 4'd1;
                end
                m_edge(p, s, ab); if (ab) return;
                m_phase = 5;
                m_edge(p, s, ab); if (ab) return;
            end
            m_phase = 6; e_over = 1'b1; e_win = (int'(e_score) >= WIN_THRESH);
            do begin m_edge(p, s, ab); if (ab) return; end while (!p);
        end
    endtask

    initial begin
        forever run_model();
    end

    // scoreboard: one compare per cycle of the whole output bundle against the model
    logic [10:0] exp_q[$];
    initial begin
        logic [10:0] act, req;
        forever begin
            @(negedge clk);
            if (m_live) begin
                exp_q.push_back({e_leds, e_led, e_clear, e_winrnd, e_score, e_over, e_win});
                req = exp_q.pop_front();
                act = {bus.leds_on, bus.led_control, bus.clear, bus.winrnd, bus.score,
                       bus.game_over, bus.win};
                checks++;
                if (act !== req) begin
                    failures++;
                    $display("FAIL outputs t=%0t actual=%b required=%b (leds,led2,clr,win,score4,over,win)",
                             $time, act, req);
                end
            end
        end
    end

    // driver tasks
    int gap      = 0;
    bit force_r0 = 1'b0;

    task automatic cyc(input bit b, input int smode);
        bus.btn      = b;
        bus.rand_bit = force_r0 ? 1'b0 : 1'($urandom_range(0, 1));
        case (smode)
            1: begin bus.slowen = 1'b1; gap = $urandom_range(1, 4); end
            2: bus.slowen = 1'b0;
            default: begin
                if (gap == 0) begin bus.slowen = 1'b1; gap = $urandom_range(1, 4); end
                else begin bus.slowen = 1'b0; gap--; end
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic wait_phase(input int ph);
        int n = 0;
        while (m_phase != ph) begin
            if (n >= 3000) begin
                checks++; failures++;
                $display("FAIL wait_phase%0d actual=timeout required=reached", ph);
                return;
            end
            cyc(1'b0, 0);
            n++;
        end
    endtask

    // kinds: 0 hit, 1 timeout, 2 early press, 3 press on terminal SHOW tick, 4 press on terminal WAIT tick
    task automatic play_round(input int kind);
        int n;
        wait_phase(2);
        case (kind)
            0: begin
                wait_phase(3);
                n = $urandom_range(1, 5);
                repeat (n - 1) cyc(1'b0, 0);
                cyc(1'b1, 0);
            end
            1: wait_phase(3);
            2: begin
                repeat ($urandom_range(0, 2)) cyc(1'b0, 0);
                cyc(1'b1, 0);
            end
            3: begin
                wait_phase(3);
                n = 0;
                while (m_phase == 3 && m_ticks < WINDOW - 1 && n < 2000) begin cyc(1'b0, 0); n++; end
                cyc(1'b1, 1);
            end
            default: begin
                n = 0;
                while (m_phase == 2 && m_ticks < m_need - 1 && n < 2000) begin cyc(1'b0, 0); n++; end
                cyc(1'b1, 1);
            end
        endcase
    endtask

    int plan_a[7] = '{1, 2, 0, 0, 0, 0, 0};
    int plan_b[8] = '{3, 0, 0, 0, 0, 1, 2, 4};

    initial begin
        int cnt;
        bit seen_clear;
        rst = 1'b1;
        bus.btn = 1'b1; bus.slowen = 1'b0; bus.rand_bit = 1'b0;
        repeat (3) cyc(1'b1, 2);
        rst = 1'b0;

        // held button through reset is not a start
        seen_clear = 1'b0;
        repeat (4) begin cyc(1'b1, 0); seen_clear |= bus.clear; end
        check_lit("held_btn_no_start", int'(seen_clear), 0);
        repeat (3) cyc(1'b0, 0);
        check_lit("idle_game_over", int'(bus.game_over), 0);

        // game A, round 1: fixed pre-delay with rand forced low, hit on 3rd SHOW cycle
        force_r0 = 1'b1;
        repeat (5) cyc(1'b0, 0);
        cyc(1'b1, 0);
        check_lit("start_clear", int'(bus.clear), 1);
        cyc(1'b0, 0);
        check_lit("clear_one_cycle", int'(bus.clear), 0);
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc(1'b0, 0);
            if (bus.slowen) cnt++;
            if (bus.leds_on) break;
        end
        check_lit("predelay_ticks", cnt, MIN_DELAY);
        check_lit("predelay_led", int'(bus.led_control), 0);
        force_r0 = 1'b0;
        cyc(1'b0, 0);
        cyc(1'b0, 0);
        cyc(1'b1, 0);
        check_lit("hit_winrnd", int'(bus.winrnd), 1);
        check_lit("hit_score", int'(bus.score), 1);
        check_lit("hit_leds_off", int'(bus.leds_on), 0);
        cyc(1'b0, 0);
        check_lit("hit_winrnd_width", int'(bus.winrnd), 0);
        foreach (plan_a[i]) play_round(plan_a[i]);
        wait_phase(6);
        check_lit("gameA_over", int'(bus.game_over), 1);
        check_lit("gameA_win", int'(bus.win), 1);
        check_lit("gameA_score", int'(bus.score), 6);

        // restart from DONE starts game B
        cyc(1'b1, 0);
        check_lit("restart_clear", int'(bus.clear), 1);
        check_lit("restart_score", int'(bus.score), 0);
        foreach (plan_b[i]) play_round(plan_b[i]);
        wait_phase(6);
        check_lit("gameB_over", int'(bus.game_over), 1);
        check_lit("gameB_win", int'(bus.win), 0);
        check_lit("gameB_score", int'(bus.score), 5);

        // random games
        repeat (2) begin
            cyc(1'b1, 0);
            for (int r = 0; r < ROUNDS; r++) play_round($urandom_range(0, 4));
            wait_phase(6);
            repeat ($urandom_range(1, 6)) cyc(1'b0, 0);
        end

        // reset in the middle of SHOW
        cyc(1'b1, 0);
        wait_phase(3);
        cyc(1'b0, 0);
        rst = 1'b1;
        cyc(1'b0, 0);
        check_lit("rst_leds_on", int'(bus.leds_on), 0);
        check_lit("rst_led_control", int'(bus.led_control), 0);
        check_lit("rst_score", int'(bus.score), 0);
        check_lit("rst_flags", int'({bus.clear, bus.winrnd, bus.game_over, bus.win}), 0);
        rst = 1'b0;
        repeat (4) cyc(1'b0, 0);
        check_lit("after_rst_idle", int'({bus.leds_on, bus.clear}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
